dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Two-master arbiter that shares the single-port data memory between requester A (CPU memory stage) and requester B (DMA/debug bridge). Each cycle it accepts at most one request, registers it into a command stage and drives the memory write/address/byte-enable port from that register. It captures read data into a response register. It sits between the pipeline's memory stage, the bridge and the data memory; the memory has combinational read and a synchronous write at posedge.

Parameters:
ADDR_LIMIT, 32'h0000_3000, first byte address outside data memory (12 KB window); requests at or above it are errors
RESET_PRIO, 1'b0, requester given priority after reset (0 = A, 1 = B)

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; clears all state at posedge
req_a  input  1  requester A access request, held until gnt_a
we_a  input  1  A: 1 = write, 0 = read
addr_a  input  32  A byte address
wdata_a  input  32  A write data, already lane-aligned
be_a  input  4  A byte enables
pc_a  input  32  A instruction PC, forwarded for the write log
gnt_a  output  1  A request accepted this cycle (combinational)
req_b, we_b, addr_b, wdata_b, be_b  input  1/1/32/32/4  requester B, same meaning (no PC)
gnt_b  output  1  B request accepted this cycle (combinational)
rdata  output  32  read data, valid with rvalid_a or rvalid_b
rvalid_a  output  1  one-cycle pulse: A read data on rdata
rvalid_b  output  1  one-cycle pulse: B read data on rdata
err_a  output  1  one-cycle pulse: A request was out of range
err_b  output  1  one-cycle pulse: B request was out of range
mem_we  output  1  memory write strobe
mem_addr  output  32  memory address
mem_din  output  32  memory write data
mem_be  output  4  memory byte enables
mem_pc  output  32  PC for the memory write log; 32'h0 for B accesses
mem_dout  input  32  memory combinational read data

Behaviour:
- Arbitration, combinational in cycle N: only one requester asserts req -> it is granted. Both assert req -> the requester not granted most recently is granted (round-robin pointer). The pointer updates only on a granted conflict or a single grant, and points to the other requester after each grant. After reset the pointer selects RESET_PRIO.
- Exactly one gnt is high per cycle at most. gnt is never high without the matching req.
- Command register, loaded at the edge ending cycle N: cmd_valid, src, we, addr, wdata, be, pc, oor. oor = (addr >= ADDR_LIMIT). With no grant, cmd_valid <= 0.
- Issue in cycle N+1, from the command register:
  - mem_we = cmd_valid & we & ~oor & (be != 0).
  - mem_addr, mem_din, mem_be and mem_pc come from the register.
  - When idle: mem_we = 0 and mem_be = 0; the other mem_* hold their last values.
  - The memory write commits at the edge ending N+1.
- Response, cycle N+2 (registered at the edge ending N+1):
  - Read with ~oor -> rdata <= mem_dout, and rvalid_src pulses for 1 cycle.
  - oor (read or write) -> err_src pulses for 1 cycle; no memory write; rdata unchanged.
  - In-range write -> no response pulse.
- Latency: read grant-to-rvalid is 2 cycles. Throughput is one access per cycle, with no bubbles between back-to-back grants.
- Ordering: a read granted the cycle after a write to the same word returns the new data, because the write commits before the read is issued.
- be == 0 write: accepted and granted, no memory write, no error.
- Reset mid-operation: cmd_valid, rvalid_*, err_* and mem_we go to 0 at the reset edge. The pending read is discarded and never reported. rdata resets to 0 and the pointer resets to RESET_PRIO. gnt_* are 0 while reset is high.
- Requesters must hold req and all request fields stable until gnt. Dropping req before gnt is allowed (request withdrawn).

Test Plan:
- A read only: mem[0x10] = 32'hDEADBEEF, req_a/we_a=0/addr_a=0x10 in cycle 1 -> gnt_a in cycle 1, mem_addr=0x10 in cycle 2, rvalid_a=1 and rdata=32'hDEADBEEF in cycle 3.
- Conflict: req_a and req_b held from cycle 1 after reset, RESET_PRIO=0 -> grants A, B, A, B in cycles 1-4; never both gnt in one cycle.
- Write then read: A writes 32'h12345678 be=4'b1111 to 0x20 in cycle 1, B reads 0x20 in cycle 2 -> rvalid_b in cycle 4 with rdata=32'h12345678; mem_pc=pc_a in cycle 2 and 0 in cycle 3.
- Out of range: B writes addr 0x3000 -> gnt_b, mem_we stays 0, err_b pulses 2 cycles after grant, and memory is unchanged.
- Reset mid-read: A read granted in cycle 1, reset high in cycle 2 -> no rvalid_a in cycle 3; all outputs 0 in cycle 3; pointer back to A.
- Byte write: A writes be=4'b0100, wdata=32'h00AB0000 to 0x40 (was 0) -> mem_be=4'b0100 with mem_we=1; a later read returns 32'h00AB0000. A be=0 write to 0x40 -> mem_we stays 0 and the word is unchanged.

Source files
------------

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Two-master arbiter for the single-port data memory. Requester A is the CPU
// memory stage. Requester B is the DMA/debug bridge.
//
// Each cycle at most one request is granted. The grant is combinational. The
// granted request is registered into a command stage, and that stage drives
// the memory port in the following cycle. The memory reads combinationally
// and writes at posedge, so a write issued in cycle N+1 commits at the edge
// that ends N+1. Read data is captured into a response register, which gives
// a grant-to-rvalid latency of two cycles.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   req_a/we_a/addr_a/   requester A request, direction, byte address,
//   wdata_a/be_a/pc_a    lane-aligned write data, byte enables, PC for the log
//   gnt_a                A accepted this cycle (combinational)
//   req_b/we_b/addr_b/   requester B, same meaning (no PC)
//   wdata_b/be_b
//   gnt_b                B accepted this cycle (combinational)
//   rdata                read data, valid with rvalid_a / rvalid_b
//   rvalid_a, rvalid_b   one-cycle read-data pulses per requester
//   err_a, err_b         one-cycle out-of-range pulses per requester
//   mem_we/mem_addr/     memory write strobe, address, write data,
//   mem_din/mem_be       byte enables
//   mem_pc               PC for the memory write log (0 for B accesses)
//   mem_dout             memory combinational read data
// -----------------------------------------------------------------------------
module dm_arbiter #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000,
   parameter logic        RESET_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_a,
   input  logic        we_a,
   input  logic [31:0] addr_a,
   input  logic [31:0] wdata_a,
   input  logic [3:0]  be_a,
   input  logic [31:0] pc_a,
   output logic        gnt_a,
   input  logic        req_b,
   input  logic        we_b,
   input  logic [31:0] addr_b,
   input  logic [31:0] wdata_b,
   input  logic [3:0]  be_b,
   output logic        gnt_b,
   output logic [31:0] rdata,
   output logic        rvalid_a,
   output logic        rvalid_b,
   output logic        err_a,
   output logic        err_b,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_pc,
   input  logic [31:0] mem_dout
);

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   // Address lies at or beyond the end of the data memory window.
   function automatic logic out_of_range(input logic [31:0] addr);
      return (addr >= ADDR_LIMIT);
   endfunction

   // At least one byte lane is enabled.
   function automatic logic lanes_active(input logic [3:0] be);
      return (be != 4'b0000);
   endfunction

   // Arbitration
   logic        prio_r;        // requester favoured on the next conflict
   logic        gnt_a_s;
   logic        gnt_b_s;
   logic        grant_s;

   // Granted request, muxed from the winning requester
   logic        sel_src_s;
   logic        sel_we_s;
   logic [31:0] sel_addr_s;
   logic [31:0] sel_wdata_s;
   logic [3:0]  sel_be_s;
   logic [31:0] sel_pc_s;
   logic        sel_oor_s;

   // Command stage; the mem_* registers double as the command fields
   logic        cmd_valid_r;
   logic        cmd_src_r;
   logic        cmd_we_r;
   logic        cmd_oor_r;
   logic        mem_we_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_din_r;
   logic [3:0]  mem_be_r;
   logic [31:0] mem_pc_r;

   // Response stage
   logic        rd_done_s;
   logic        err_done_s;
   logic [31:0] rdata_r;
   logic        rvalid_a_r;
   logic        rvalid_b_r;
   logic        err_a_r;
   logic        err_b_r;

   // Grant logic: a lone requester wins; on a conflict the pointer decides.
   always_comb begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
      if (reset) begin
         gnt_a_s = 1'b0;
         gnt_b_s = 1'b0;
      end else if (req_a && req_b) begin
         if (prio_r == SRC_B) begin
            gnt_b_s = 1'b1;
         end else begin
            gnt_a_s = 1'b1;
         end
      end else if (req_a) begin
         gnt_a_s = 1'b1;
      end else if (req_b) begin
         gnt_b_s = 1'b1;
      end else begin
         gnt_a_s = 1'b0;
         gnt_b_s = 1'b0;
      end
   end

   assign grant_s = gnt_a_s | gnt_b_s;

   // Request mux: select the fields of whichever requester was granted.
   always_comb begin
      sel_src_s   = SRC_A;
      sel_we_s    = 1'b0;
      sel_addr_s  = 32'h0000_0000;
      sel_wdata_s = 32'h0000_0000;
      sel_be_s    = 4'b0000;
      sel_pc_s    = 32'h0000_0000;
      case ({gnt_b_s, gnt_a_s})
         2'b01: begin
            sel_src_s   = SRC_A;
            sel_we_s    = we_a;
            sel_addr_s  = addr_a;
            sel_wdata_s = wdata_a;
            sel_be_s    = be_a;
            sel_pc_s    = pc_a;
         end
         2'b10: begin
            sel_src_s   = SRC_B;
            sel_we_s    = we_b;
            sel_addr_s  = addr_b;
            sel_wdata_s = wdata_b;
            sel_be_s    = be_b;
            // The bridge has no PC, so its writes are logged with PC 0.
            sel_pc_s    = 32'h0000_0000;
         end
         default: begin
            sel_src_s   = SRC_A;
            sel_we_s    = 1'b0;
            sel_addr_s  = 32'h0000_0000;
            sel_wdata_s = 32'h0000_0000;
            sel_be_s    = 4'b0000;
            sel_pc_s    = 32'h0000_0000;
         end
      endcase
      sel_oor_s = out_of_range(sel_addr_s);
   end

   // Round-robin pointer: after any grant it points at the other requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_r <= RESET_PRIO;
      end else if (gnt_a_s) begin
         prio_r <= SRC_B;
      end else if (gnt_b_s) begin
         prio_r <= SRC_A;
      end else begin
         prio_r <= prio_r;
      end
   end

   // Command stage: capture the granted request. The write strobe is
   // precomputed here so that the memory port is driven purely from flops.
   // With no grant, address/data/PC keep their last values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_valid_r <= 1'b0;
         cmd_src_r   <= SRC_A;
         cmd_we_r    <= 1'b0;
         cmd_oor_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_din_r   <= 32'h0000_0000;
         mem_be_r    <= 4'b0000;
         mem_pc_r    <= 32'h0000_0000;
      end else if (grant_s) begin
         cmd_valid_r <= 1'b1;
         cmd_src_r   <= sel_src_s;
         cmd_we_r    <= sel_we_s;
         cmd_oor_r   <= sel_oor_s;
         mem_we_r    <= sel_we_s & ~sel_oor_s & lanes_active(sel_be_s);
         mem_addr_r  <= sel_addr_s;
         mem_din_r   <= sel_wdata_s;
         mem_be_r    <= sel_be_s;
         mem_pc_r    <= sel_pc_s;
      end else begin
         cmd_valid_r <= 1'b0;
         cmd_src_r   <= cmd_src_r;
         cmd_we_r    <= cmd_we_r;
         cmd_oor_r   <= cmd_oor_r;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= mem_addr_r;
         mem_din_r   <= mem_din_r;
         mem_be_r    <= 4'b0000;
         mem_pc_r    <= mem_pc_r;
      end
   end

   // Classify the access currently issued to memory.
   assign rd_done_s  = cmd_valid_r & ~cmd_we_r & ~cmd_oor_r;
   assign err_done_s = cmd_valid_r & cmd_oor_r;

   // Response stage: capture read data and raise the per-source pulses.
   // In-range writes produce no response; rdata holds between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_r    <= 32'h0000_0000;
         rvalid_a_r <= 1'b0;
         rvalid_b_r <= 1'b0;
         err_a_r    <= 1'b0;
         err_b_r    <= 1'b0;
      end else begin
         rvalid_a_r <= rd_done_s  & (cmd_src_r == SRC_A);
         rvalid_b_r <= rd_done_s  & (cmd_src_r == SRC_B);
         err_a_r    <= err_done_s & (cmd_src_r == SRC_A);
         err_b_r    <= err_done_s & (cmd_src_r == SRC_B);
         if (rd_done_s) begin
            rdata_r <= mem_dout;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   assign gnt_a    = gnt_a_s;
   assign gnt_b    = gnt_b_s;
   assign mem_we   = mem_we_r;
   assign mem_addr = mem_addr_r;
   assign mem_din  = mem_din_r;
   assign mem_be   = mem_be_r;
   assign mem_pc   = mem_pc_r;
   assign rdata    = rdata_r;
   assign rvalid_a = rvalid_a_r;
   assign rvalid_b = rvalid_b_r;
   assign err_a    = err_a_r;
   assign err_b    = err_b_r;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Bench for dm_arbiter. It contains a 12 KB word memory that the DUT drives.
// A reference model works at transaction level. It decides each grant from
// the round-robin rule. It applies the granted access to its own copy of
// memory in grant order, then schedules the expected issue one cycle later
// and the expected response two cycles later. Outputs are compared on every
// falling edge. Directed stimulus adds literal checks at known points.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

   localparam logic [31:0] LIMIT = 32'h0000_3000;
   localparam logic        PRIO0 = 1'b0;
   localparam int          NW    = 3072;
   localparam int          NSLOT = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_a, we_a, req_b, we_b;
   logic [31:0] addr_a, wdata_a, pc_a, addr_b, wdata_b;
   logic [3:0]  be_a, be_b;
   logic        gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b, mem_we;
   logic [31:0] rdata, mem_addr, mem_din, mem_pc, mem_dout;
   logic [3:0]  mem_be;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   dm_arbiter #(.ADDR_LIMIT(LIMIT), .RESET_PRIO(PRIO0)) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .be_a(be_a), .pc_a(pc_a), .gnt_a(gnt_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .be_b(be_b), .gnt_b(gnt_b),
      .rdata(rdata), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
      .err_a(err_a), .err_b(err_b),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_be(mem_be), .mem_pc(mem_pc), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      case (i)
         4:       return 32'hDEAD_BEEF;   // 0x10
         5:       return 32'h55AA_0001;   // 0x14
         3071:    return 32'hCAFE_F00D;   // 0x2FFC, last word in range
         default: return 32'h0000_0000;
      endcase
   endfunction

   // ---------------- environment memory driven by the DUT ----------------
   logic [31:0] bmem [0:NW-1];
   bit          bm_init = 1'b0;

   assign mem_dout = (mem_addr < LIMIT) ? bmem[mem_addr[13:2]] : 32'h0000_0000;

   always @(posedge clk) begin
      if (!bm_init) begin
         for (int i = 0; i < NW; i++) bmem[i] <= init_word(i);
         bm_init <= 1'b1;
      end else if (mem_we && (mem_addr < LIMIT)) begin
         for (int k = 0; k < 4; k++)
            if (mem_be[k]) bmem[mem_addr[13:2]][8*k +: 8] <= mem_din[8*k +: 8];
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %0b, want %0b", name, cyc, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   logic [31:0] mmem [0:NW-1];
   bit          mm_init = 1'b0;
   bit          armed   = 1'b0;
   bit          last_b;              // B was the most recent grantee
   logic [31:0] exp_rdata = 32'h0000_0000;

   bit          s_iv   [NSLOT];
   bit          s_mwe  [NSLOT];
   logic [31:0] s_addr [NSLOT];
   logic [31:0] s_din  [NSLOT];
   logic [3:0]  s_be   [NSLOT];
   logic [31:0] s_pc   [NSLOT];
   bit          s_rva  [NSLOT];
   bit          s_rvb  [NSLOT];
   bit          s_erra [NSLOT];
   bit          s_errb [NSLOT];
   logic [31:0] s_rd   [NSLOT];
   bit          s_clr  [NSLOT];

   bit          ga, gb, t_we, t_oor;
   logic [31:0] t_addr, t_data, t_pc, w;
   logic [3:0]  t_be;
   int          c, n1, n2;

   always @(negedge clk) begin
      if (!mm_init) begin
         for (int i = 0; i < NW; i++) mmem[i] = init_word(i);
         mm_init = 1'b1;
      end
      c  = cyc % NSLOT;
      n1 = (cyc + 1) % NSLOT;
      n2 = (cyc + 2) % NSLOT;

      ga = 1'b0;
      gb = 1'b0;
      if (!reset) begin
         if (req_a && req_b) begin
            gb = !last_b;
            ga = last_b;
         end else begin
            ga = req_a;
            gb = req_b;
         end
      end

      if (armed) begin
         if (s_clr[c]) exp_rdata = 32'h0000_0000;
         if (s_rva[c] || s_rvb[c]) exp_rdata = s_rd[c];
         chk1("gnt_a", gnt_a, ga);
         chk1("gnt_b", gnt_b, gb);
         chk1("mem_we", mem_we, s_iv[c] & s_mwe[c]);
         chk32("mem_be", 32'(mem_be), s_iv[c] ? 32'(s_be[c]) : 32'h0);
         if (s_iv[c]) begin
            chk32("mem_addr", mem_addr, s_addr[c]);
            chk32("mem_din", mem_din, s_din[c]);
            chk32("mem_pc", mem_pc, s_pc[c]);
         end
         chk1("rvalid_a", rvalid_a, s_rva[c]);
         chk1("rvalid_b", rvalid_b, s_rvb[c]);
         chk1("err_a", err_a, s_erra[c]);
         chk1("err_b", err_b, s_errb[c]);
         chk32("rdata", rdata, exp_rdata);
      end

      if (reset) begin
         last_b    = !PRIO0;
         s_rva[n1] = 1'b0;
         s_rvb[n1] = 1'b0;
         s_erra[n1] = 1'b0;
         s_errb[n1] = 1'b0;
         s_clr[n1] = 1'b1;
         armed     = 1'b1;
      end else if (ga || gb) begin
         t_we   = gb ? we_b : we_a;
         t_addr = gb ? addr_b : addr_a;
         t_data = gb ? wdata_b : wdata_a;
         t_be   = gb ? be_b : be_a;
         t_pc   = gb ? 32'h0000_0000 : pc_a;
         t_oor  = (t_addr >= LIMIT);
         s_iv[n1]   = 1'b1;
         s_mwe[n1]  = t_we && !t_oor && (t_be != 4'b0000);
         s_addr[n1] = t_addr;
         s_din[n1]  = t_data;
         s_be[n1]   = t_be;
         s_pc[n1]   = t_pc;
         if (t_oor) begin
            s_erra[n2] = ga;
            s_errb[n2] = gb;
         end else if (!t_we) begin
            s_rva[n2] = ga;
            s_rvb[n2] = gb;
            s_rd[n2]  = mmem[t_addr[13:2]];
         end else begin
            w = mmem[t_addr[13:2]];
            for (int k = 0; k < 4; k++)
               if (t_be[k]) w[8*k +: 8] = t_data[8*k +: 8];
            mmem[t_addr[13:2]] = w;
         end
         last_b = gb;
      end

      s_iv[c]   = 1'b0;
      s_mwe[c]  = 1'b0;
      s_rva[c]  = 1'b0;
      s_rvb[c]  = 1'b0;
      s_erra[c] = 1'b0;
      s_errb[c] = 1'b0;
      s_clr[c]  = 1'b0;
   end

   // ---------------- stimulus ----------------
   task automatic apply(input logic rst,
                        input logic ra, input logic wa, input logic [31:0] aa,
                        input logic [31:0] da, input logic [3:0] ba, input logic [31:0] pa,
                        input logic rb, input logic wb, input logic [31:0] ab,
                        input logic [31:0] db, input logic [3:0] bb);
      @(posedge clk);
      #1;
      reset = rst;
      req_a = ra; we_a = wa; addr_a = aa; wdata_a = da; be_a = ba; pc_a = pa;
      req_b = rb; we_b = wb; addr_b = ab; wdata_b = db; be_b = bb;
      @(negedge clk);
   endtask

   task automatic idle();
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   int bad;

   initial begin
      reset = 1'b1;
      req_a = 1'b0; we_a = 1'b0; addr_a = 32'h0; wdata_a = 32'h0; be_a = 4'h0; pc_a = 32'h0;
      req_b = 1'b0; we_b = 1'b0; addr_b = 32'h0; wdata_b = 32'h0; be_b = 4'h0;

      // Reset; A requesting during reset must not be granted
      apply(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      apply(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk1("gnt_a_in_reset", gnt_a, 1'b0);

      // Conflict: both hold reads, expect A, B, A, B
      apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
      chk1("cf1_gnt_a", gnt_a, 1'b1);
      chk1("cf1_gnt_b", gnt_b, 1'b0);
      apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
      chk1("cf2_gnt_b", gnt_b, 1'b1);
      apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
      chk1("cf3_gnt_a", gnt_a, 1'b1);
      chk1("cf3_rvalid_a", rvalid_a, 1'b1);
      chk32("cf3_rdata", rdata, 32'hDEAD_BEEF);
      apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
      chk1("cf4_gnt_b", gnt_b, 1'b1);
      chk1("cf4_rvalid_b", rvalid_b, 1'b1);
      chk32("cf4_rdata", rdata, 32'h55AA_0001);
      idle();
      idle();

      // A read only
      apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk1("rd_gnt_a", gnt_a, 1'b1);
      idle();
      chk32("rd_mem_addr", mem_addr, 32'h10);
      chk1("rd_mem_we", mem_we, 1'b0);
      idle();
      chk1("rd_rvalid_a", rvalid_a, 1'b1);
      chk32("rd_rdata", rdata, 32'hDEAD_BEEF);

      // A writes 0x20, B reads it back the next cycle
      apply(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0000_0ACC, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk1("wr_gnt_a", gnt_a, 1'b1);
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
      chk1("wr_gnt_b", gnt_b, 1'b1);
      chk1("wr_mem_we", mem_we, 1'b1);
      chk32("wr_mem_pc", mem_pc, 32'h0000_0ACC);
      idle();
      chk1("wrb_mem_we", mem_we, 1'b0);
      chk32("wrb_mem_pc", mem_pc, 32'h0);
      idle();
      chk1("wrb_rvalid_b", rvalid_b, 1'b1);
      chk32("wrb_rdata", rdata, 32'h1234_5678);

      // Out of range: B writes 0x3000, then A reads 0x3000 against B reading 0x2FFC
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'hFFFF_FFFF, 4'hF);
      chk1("oor_gnt_b", gnt_b, 1'b1);
      apply(1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h2FFC, 32'h0, 4'hF);
      chk1("oor_mem_we", mem_we, 1'b0);
      chk1("oor_gnt_a", gnt_a, 1'b1);
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h2FFC, 32'h0, 4'hF);
      chk1("oor_gnt_b2", gnt_b, 1'b1);
      chk1("oor_err_b", err_b, 1'b1);
      idle();
      chk1("oor_err_a", err_a, 1'b1);
      idle();
      chk1("edge_rvalid_b", rvalid_b, 1'b1);
      chk32("edge_rdata", rdata, 32'hCAFE_F00D);

      // Byte write, be==0 write, then read back
      apply(1'b0, 1'b1, 1'b1, 32'h40, 32'h00AB_0000, 4'b0100, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      apply(1'b0, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk32("bw_mem_be", 32'(mem_be), 32'h4);
      chk1("bw_mem_we", mem_we, 1'b1);
      apply(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h108, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk1("be0_mem_we", mem_we, 1'b0);
      idle();
      chk1("be0_err_a", err_a, 1'b0);
      idle();
      chk1("bw_rvalid_a", rvalid_a, 1'b1);
      chk32("bw_rdata", rdata, 32'h00AB_0000);

      // Reset while a read is in flight
      apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      chk1("rst_gnt_a", gnt_a, 1'b1);
      apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
      chk1("rst_gnt_b", gnt_b, 1'b0);
      idle();
      chk1("rst_rvalid_a", rvalid_a, 1'b0);
      chk32("rst_rdata", rdata, 32'h0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      chk32("rst_mem_din", mem_din, 32'h0);
      chk32("rst_mem_pc", mem_pc, 32'h0);
      chk1("rst_mem_we", mem_we, 1'b0);
      apply(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0, 4'hF);
      chk1("rst_prio_gnt_a", gnt_a, 1'b1);
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0, 4'hF);
      chk1("rst_next_gnt_b", gnt_b, 1'b1);
      idle();
      idle();
      idle();

      // Whole memory image must match the model's
      bad = -1;
      for (int i = 0; i < NW; i++)
         if (bad < 0 && bmem[i] !== mmem[i]) bad = i;
      vectors++;
      if (bad >= 0) begin
         miscompares++;
         $display("FAIL mem_image word %0d: got %h, want %h", bad, bmem[bad], mmem[bad]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
